// File: rtl/seq_window_detector.sv
// Serial pattern detector; counts matches per window of WIN_LEN accepted bits.
// Define SEQ_DET_MASK_EN to add pattern_mask (0 bits are don't-care).
module seq_window_detector #(
  parameter int PAT_W   = 4,
  parameter int WIN_LEN = 20,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PAT_W-1:0] pattern,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0] pattern_mask,
`endif
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             overlap,
  output logic             match,
  output logic [CNT_W-1:0] count,
  output logic             count_valid
);

  localparam int WIN_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int FILL_W = $clog2(PAT_W + 1);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0]  ACC_MAX   = '1;

  typedef enum logic {
    FILL,
    HUNT
  } state_t;

  state_t state, state_n;

  logic [PAT_W-1:0]  shreg;
  logic [PAT_W-1:0]  shreg_n;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_inc;
  logic [FILL_W-1:0] fill_n;
  logic [CNT_W-1:0]  acc;
  logic [CNT_W-1:0]  acc_sum;
  logic [CNT_W-1:0]  acc_n;
  logic [WIN_W-1:0]  win_cnt;
  logic [WIN_W-1:0]  win_n;
  logic              cmp;
  logic              hit;
  logic              win_end;

  always_comb begin
    shreg_n = shreg >> 1;
    shreg_n[PAT_W-1] = bit_in;
  end

  assign fill_inc = (fill == FILL_FULL) ? fill : fill + 1'b1;

`ifdef SEQ_DET_MASK_EN
  assign cmp = (((shreg_n ^ pattern) & pattern_mask) == '0);
`else
  assign cmp = (shreg_n == pattern);
`endif

  assign hit     = bit_valid && (fill_inc == FILL_FULL) && cmp;
  assign win_end = bit_valid && (win_cnt == WIN_LAST);
  assign acc_sum = (hit && acc != ACC_MAX) ? acc + 1'b1 : acc;

  always_comb begin
    state_n = state;
    fill_n  = fill;
    acc_n   = acc;
    win_n   = win_cnt;
    if (bit_valid) begin
      fill_n = fill_inc;
      acc_n  = acc_sum;
      win_n  = win_cnt + 1'b1;
      unique case (state)
        FILL: if (fill_inc == FILL_FULL) state_n = HUNT;
        HUNT: state_n = HUNT;
        default: state_n = FILL;
      endcase
      // A non-overlapping hit needs PAT_W fresh bits before the next one.
      if (hit && !overlap) begin
        fill_n  = '0;
        state_n = FILL;
      end
      if (win_end) begin
        fill_n  = '0;
        acc_n   = '0;
        win_n   = '0;
        state_n = FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      shreg       <= '0;
      fill        <= '0;
      acc         <= '0;
      win_cnt     <= '0;
      match       <= 1'b0;
      count       <= '0;
      count_valid <= 1'b0;
    end else begin
      state       <= state_n;
      fill        <= fill_n;
      acc         <= acc_n;
      win_cnt     <= win_n;
      match       <= hit;
      count_valid <= win_end;
      if (bit_valid) shreg <= shreg_n;
      if (win_end) count <= acc_sum;
    end
  end

endmodule

// File: tb/tb_seq_window_detector.sv
// Scoreboard bench: driver queues expected match/count events,
// monitor pops and compares them as the DUTs present outputs.
module tb_seq_window_detector;

  bit         clk;
  logic       rst;
  logic [3:0] pattern;
  logic       bit_in;
  logic       bit_valid;
  logic       overlap;
  logic       match;
  logic [4:0] count;
  logic       count_valid;
  logic       s_match;
  logic [1:0] s_count;
  logic       s_count_valid;

  seq_window_detector #(.PAT_W(4), .WIN_LEN(20), .CNT_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .pattern(pattern),
`ifdef SEQ_DET_MASK_EN
    .pattern_mask(4'b1111),
`endif
    .bit_in(bit_in),
    .bit_valid(bit_valid),
    .overlap(overlap),
    .match(match),
    .count(count),
    .count_valid(count_valid)
  );

  seq_window_detector #(.PAT_W(4), .WIN_LEN(20), .CNT_W(2)) dut_s (
    .clk(clk),
    .rst(rst),
    .pattern(pattern),
`ifdef SEQ_DET_MASK_EN
    .pattern_mask(4'b1111),
`endif
    .bit_in(bit_in),
    .bit_valid(bit_valid),
    .overlap(overlap),
    .match(s_match),
    .count(s_count),
    .count_valid(s_count_valid)
  );

  always #5 clk = ~clk;

  int mq[$];
  int cq_idx[$];
  int cq_cnt[$];
  int idx;
  int sent;
  int base;
  int total;
  int passed;
  logic rst_probe;
  logic done;

  always @(posedge clk)
    if (!rst && bit_valid) idx <= idx + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    int e;
    int c;
    if (rst_probe) begin
      chk("rst_count", int'(count), 0);
      chk("rst_match", int'(match), 0);
      chk("rst_count_valid", int'(count_valid), 0);
      chk("rst_sat_count", int'(s_count), 0);
    end
    if (!rst) begin
      if (match) begin
        e = (mq.size() > 0) ? mq.pop_front() : -1;
        chk("match_bit", idx, e);
      end
      if (count_valid) begin
        e = (cq_idx.size() > 0) ? cq_idx.pop_front() : -1;
        c = (cq_cnt.size() > 0) ? cq_cnt.pop_front() : -1;
        chk("window_end_bit", idx, e);
        chk("count", int'(count), c);
        chk("sat_count_valid", int'(s_count_valid), 1);
        chk("sat_count", int'(s_count), (c > 3) ? 3 : c);
      end
    end
    if (done) begin
      chk("match_left", mq.size(), 0);
      chk("count_left", cq_idx.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
    end
  end

  task automatic send(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    sent++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input logic [31:0] v, input int n,
                          input int gap_at, input int gap_len);
    logic [31:0] w;
    w = v;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) idle(gap_len);
      send(w[i]);
    end
  endtask

  task automatic exp_match(input int k);
    mq.push_back(base + k);
  endtask

  task automatic exp_count(input int k, input int c);
    cq_idx.push_back(base + k);
    cq_cnt.push_back(c);
  endtask

  initial begin
    rst       = 1'b1;
    rst_probe = 1'b1;
    done      = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    pattern   = 4'b1011;
    overlap   = 1'b1;
    idx       = 0;
    sent      = 0;
    total     = 0;
    passed    = 0;
    repeat (3) @(posedge clk);
    #1;
    rst       = 1'b0;
    rst_probe = 1'b0;
    idle(2);

    // overlap: 1,1,0,1,1,0,1 + 13 zeros
    base = sent;
    exp_match(4);
    exp_match(7);
    exp_count(20, 2);
    send_vec(32'h5B, 20, -1, 0);
    idle(2);

    // non-overlap
    overlap = 1'b0;
    base = sent;
    exp_match(4);
    exp_count(20, 1);
    send_vec(32'h5B, 20, -1, 0);
    idle(2);

    // gapped input, 5 idle cycles between bits 3 and 4
    overlap = 1'b1;
    base = sent;
    exp_match(4);
    exp_match(7);
    exp_count(20, 2);
    send_vec(32'h5B, 20, 3, 5);
    idle(2);

    // all-zero pattern: 17 hits, narrow instance saturates at 3
    pattern = 4'b0000;
    base = sent;
    for (int k = 4; k <= 20; k++) exp_match(k);
    exp_count(20, 17);
    send_vec(32'h0, 20, -1, 0);
    idle(2);

    // hit on the last bit of a window
    pattern = 4'b1011;
    base = sent;
    exp_match(20);
    exp_count(20, 1);
    send_vec(32'hB0000, 20, -1, 0);

    // next window restarts in FILL
    base = sent;
    exp_match(4);
    exp_count(20, 1);
    send_vec(32'hB, 20, -1, 0);
    idle(2);

    // reset mid-window discards the partial count
    base = sent;
    exp_match(4);
    send_vec(32'hB, 10, -1, 0);
    rst       = 1'b1;
    rst_probe = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    rst_probe = 1'b0;
    idle(2);
    base = sent;
    exp_match(4);
    exp_count(20, 1);
    send_vec(32'hB, 20, -1, 0);
    idle(3);

    done = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL monitor_timeout: got no summary expected summary");
    $fatal(1);
  end

endmodule

// File: doc/seq_window_detector.md
Name: seq_window_detector

Overview:
- Parametrised serial pattern detector. Counts occurrences of a PAT_W-bit pattern in a serial bit stream over fixed windows of WIN_LEN accepted bits.
- Supports run-time overlap or non-overlap matching, a valid qualifier on input bits, a per-match pulse and a saturating per-window count.
- Sits after a serial front-end; feeds the count to the status/display logic.

Parameters:
PAT_W, 4, pattern width in bits (1..16)
WIN_LEN, 20, accepted bits per counting window (>= PAT_W)
CNT_W, 5, width of the match count

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
pattern  input  PAT_W  pattern to detect; bit 0 = oldest bit of a match
bit_in  input  1  serial data bit
bit_valid  input  1  bit_in is accepted on this rising clk edge
overlap  input  1  1 = overlapping matches, 0 = non-overlapping
match  output  1  one-cycle pulse per detected match
count  output  CNT_W  match count of the last completed window
count_valid  output  1  one-cycle pulse when count updates

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high. rst clears shreg, fill, acc, win_cnt, match, count and count_valid to 0. The FSM enters FILL. Reset mid-window discards the partial window; no count_valid is issued for it.
- Cycles with bit_valid=0 change no state except that match and count_valid return to 0.
- Accepted bit (bit_valid=1):
  - next_shreg = {bit_in, shreg[PAT_W-1:1]}; the newest bit enters the MSB.
  - next_fill = min(fill+1, PAT_W).
  - hit = (next_fill == PAT_W) and (next_shreg == pattern).
- FSM state FILL (fill < PAT_W): fewer than PAT_W valid bits since the last clear. Go to HUNT when next_fill == PAT_W.
- FSM state HUNT: every accepted bit is compared against pattern.
  - On a hit with overlap=1: stay in HUNT; fill stays PAT_W.
  - On a hit with overlap=0: fill <= 0 and go to FILL. shreg keeps shifting, but stale bits cannot match until PAT_W new bits arrive.
- pattern and overlap are sampled on each accepted bit and are intended to be static within a window.
- match: registered; high for exactly one cycle after the accepted bit that produced the hit. Latency is 1 clk.
- acc: increments on each hit and saturates at 2^CNT_W-1 with no wrap.
- win_cnt: counts accepted bits from 0 to WIN_LEN-1.
- Window end, on the accepted bit where win_cnt == WIN_LEN-1 (that bit is fully evaluated first):
  - count <= sat(acc + hit); count_valid pulses for 1 cycle, 1 clk after that bit.
  - acc, win_cnt and fill are cleared and the FSM returns to FILL. Matches never span window boundaries.
- A hit on the last bit of a window raises match and count_valid in the same cycle; that hit is included in count.
- count holds its value between updates.
- Width rules: win_cnt width is clog2(WIN_LEN). All compares are unsigned.

Optional Feature:
- Macro SEQ_DET_MASK_EN. When defined, adds the input port pattern_mask (PAT_W bits). Bit positions where the mask is 0 are don't-care in the compare: hit uses (next_shreg & pattern_mask) == (pattern & pattern_mask). An all-zero mask therefore matches on every bit once fill reaches PAT_W.
- When undefined, the port does not exist and the compare is exact.

Test Plan:
- Overlap count: defaults, pattern=4'b1011, overlap=1, stream 1,1,0,1,1,0,1 then 13 zeros, bit_valid=1 -> match pulses after bits 4 and 7; count=2 with count_valid 1 clk after bit 20.
- Non-overlap count: same stream with overlap=0 -> single match after bit 4; count=1.
- Gapped input: same stream as the overlap test with bit_valid=0 inserted between bits 3 and 4 for 5 cycles -> identical results; count_valid is delayed by 5 cycles.
- Saturation: CNT_W=2, pattern=4'b0000, overlap=1, 20 zeros -> 17 match pulses; count=3.
- Boundary hit: pattern 1,1,0,1 placed on bits 17-20 -> match and count_valid in the same cycle; count=1. The next window starts in FILL, so bits 18-20 followed by the next window's bit 1 do not match.
- Reset mid-window: 10 bits containing one match, then a 1-cycle rst -> count=0, no count_valid. The next count_valid comes only after 20 more accepted bits.
